// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: captures an N-bit word over a valid/ready
// handshake and shifts it out one bit per enabled clock with frame markers.
module piso_serializer #(
    parameter int unsigned N         = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] I,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         shift_en,
    output logic         s_out,
    output logic         s_valid,
    output logic         s_last,
    output logic         busy
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   shift_reg_q, shift_reg_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   shifted;

    // A new word can be taken while idle or on the edge that consumes the last bit
    assign load_ready = (state_q == IDLE) || ((count_q == '0) && shift_en);

    assign shifted = MSB_FIRST ? (shift_reg_q << 1) : (shift_reg_q >> 1);

    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        count_d     = count_q;
        if (state_q == IDLE) begin
            if (load_valid) begin
                shift_reg_d = I;
                count_d     = LAST_CNT;
                state_d     = SHIFT;
            end
        end else if (shift_en) begin
            if (count_q != '0) begin
                shift_reg_d = shifted;
                count_d     = count_q - CW'(1);
            end else if (load_valid) begin
                shift_reg_d = I;
                count_d     = LAST_CNT;
            end else begin
                shift_reg_d = '0;
                state_d     = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            count_q     <= count_d;
        end
    end

    // Serial outputs come straight from the state flops; the register is zero while idle
    assign s_valid = (state_q == SHIFT);
    assign busy    = (state_q == SHIFT);
    assign s_last  = (state_q == SHIFT) && (count_q == '0);
    assign s_out   = MSB_FIRST ? shift_reg_q[N-1] : shift_reg_q[0];

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out transmitter. It is the serialising counterpart of the parallel register and SIPO receivers in the sequential-circuits library. It accepts an N-bit word over a valid/ready load handshake and holds it internally, independent of later changes on I. It then shifts the word out one bit per enabled clock, with frame-valid and last-bit markers. It is the drive end for a downstream SIPO receiver.

Parameters:
N, 4, word width in bits (N >= 1)
MSB_FIRST, 1, 1 = transmit I[N-1] first; 0 = transmit I[0] first

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
I  input  N  parallel data word
load_valid  input  1  upstream has a word on I
load_ready  output  1  block can accept a word this cycle
shift_en  input  1  downstream consumes current bit on this edge
s_out  output  1  current serial bit
s_valid  output  1  s_out carries a frame bit
s_last  output  1  current bit is the final bit of the word
busy  output  1  frame in progress (state == SHIFT)

Behaviour:
- One clock: clk. Reset is synchronous, active-low: sampled on the rising clk edge when reset_n = 0. No asynchronous path.
- Reset values:
  - state = IDLE, shift_reg = 0, count = 0
  - s_out = 0, s_valid = 0, s_last = 0, busy = 0, load_ready = 1
- Reset has priority over every other input.
- Count width: max($clog2(N), 1) bits. count holds the number of bits remaining after the current bit.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready = 1, s_valid = 0, s_out = 0.
  - On an edge with load_valid = 1: shift_reg <= I, count <= N-1, go to SHIFT.
  - Latency: the first bit is on s_out in the cycle after acceptance.
- SHIFT:
  - s_valid = 1, busy = 1.
  - s_out = shift_reg[N-1] when MSB_FIRST = 1, else shift_reg[0]. s_out is driven straight from the register, not from I.
  - s_last = 1 when count == 0.
  - Edge with shift_en = 1 and count > 0: shift toward the output end (zero fill), count decrements.
  - Edge with shift_en = 1 and count == 0 (last bit consumed):
    - if load_valid = 1: load the new word, count <= N-1, stay in SHIFT. This is a back-to-back frame with no idle cycle.
    - else: go to IDLE, shift_reg <= 0.
  - shift_en = 0: shift_reg, count, s_out and s_last all hold.
- load_ready = (state == IDLE) OR (state == SHIFT AND count == 0 AND shift_en == 1). This is combinational from shift_en. Downstream logic must not make shift_en depend on load_ready.
- load_valid with load_ready = 0: ignored, I not sampled. Upstream holds I and load_valid until a handshake completes.
- Changes on I after acceptance have no effect on the frame in flight.
- N = 1: every word is a single bit. s_last = 1 on every valid bit.
- Reset mid-frame: the frame is aborted and no further bits are emitted. The cycle after the reset edge shows s_valid = 0 and load_ready = 1.
- shift_en in IDLE: ignored.

Test Plan:
1. reset_n = 0 for 2 cycles with load_valid = 1, I = 4'hF -> load_ready = 1, s_valid = 0, busy = 0, s_out = 0. After release with load_valid = 0, still idle, nothing captured.
2. N = 4, MSB_FIRST = 1; accept I = 4'b1011, shift_en = 1; set I = 4'b0000 the cycle after acceptance -> s_out = 1,0,1,1 over the next 4 cycles. s_last high only on the 4th bit. Then s_valid = 0 and load_ready = 1.
3. Accept 4'b1100; drop shift_en for 3 cycles after the 2nd bit is consumed -> s_out = 0, s_valid = 1, s_last = 0 stable for those 3 cycles. The full bit stream is 1,1,0,0, spanning 7 valid cycles.
4. Back-to-back: load_valid held with 4'hA, then 4'h5 presented after the first acceptance; shift_en = 1 -> 8 consecutive valid bits 1,0,1,0,0,1,0,1 with no gap. s_last high on bits 4 and 8. load_ready pulses high on the bit-4 cycle.
5. MSB_FIRST = 0, I = 4'b0001 -> s_out = 1,0,0,0. Repeat with N = 1, I = 1 -> single bit 1 with s_last = 1.
6. Accept 4'hC, consume 2 bits, then assert reset_n = 0 for 1 cycle -> next cycle s_valid = 0 and load_ready = 1. A following load of 4'hF yields exactly 1,1,1,1.
